// File: rtl/qpsk_symbol_framer_if.sv
// Stream bundle between a tone-pair source and the QPSK symbol framer.
// The master side drives tone pairs and rotation; the slave side returns the framed symbol stream.
interface qpsk_symbol_framer_if #(
    parameter int DATA_W = 16
) ();
    logic                     in_valid;
    logic                     in_ready;
    logic [1:0]               in_bits1;
    logic [1:0]               in_bits2;
    logic [1:0]               quad_rot;
    logic                     out_valid;
    logic signed [DATA_W-1:0] X1_re;
    logic signed [DATA_W-1:0] X1_im;
    logic signed [DATA_W-1:0] X2_re;
    logic signed [DATA_W-1:0] X2_im;
    logic                     sym_start;
    logic                     sym_end;
    logic [15:0]              sym_cnt;

    modport master (
        output in_valid, in_bits1, in_bits2, quad_rot,
        input  in_ready, out_valid, X1_re, X1_im, X2_re, X2_im, sym_start, sym_end, sym_cnt
    );

    modport slave (
        input  in_valid, in_bits1, in_bits2, quad_rot,
        output in_ready, out_valid, X1_re, X1_im, X2_re, X2_im, sym_start, sym_end, sym_cnt
    );
endinterface

// File: rtl/qpsk_symbol_framer.sv
// Maps two QPSK bit streams to constellation points, frames them into NFFT-tone symbols through a
// ping-pong buffer and emits each symbol back-to-back with a per-symbol quadrant rotation.
module qpsk_symbol_framer #(
    parameter int                        DATA_W = 16,
    parameter int                        NFFT   = 64,
    parameter logic signed [DATA_W-1:0]  AMP    = 16'sd1608
) (
    input  logic                clk,
    input  logic                rst_n,
    qpsk_symbol_framer_if.slave frame_io
);
    localparam int                       AW   = $clog2(NFFT);
    localparam int                       SW   = 2 * DATA_W;
    localparam logic [AW-1:0]            LAST = AW'(NFFT - 1);
    localparam logic signed [DATA_W-1:0] NAMP = -AMP;
    localparam logic [0:0]               IDLE = 1'b0;
    localparam logic [0:0]               RUN  = 1'b1;

    logic            wrBank_q, wrBank_d;
    logic [AW-1:0]   wrCnt_q, wrCnt_d;
    logic [1:0]      full_q, full_d;
    logic            rdBank_q, rdBank_d;
    logic [AW-1:0]   rdCnt_q, rdCnt_d;
    logic [0:0]      state_q, state_d;
    logic [1:0]      rot_q, rot_d;
    logic            wrEn, rdEn;
    logic [2*SW-1:0] wrWord;
    logic [2*SW-1:0] rdData_q;
    logic [2*SW-1:0] mem [0:2*NFFT-1];
    logic            rdValid_q, rdFirst_q, rdLast_q;
    logic            outValid_q, symStart_q, symEnd_q;
    logic [2*SW-1:0] xOut_q;
    logic [15:0]     symCnt_q;

    function automatic logic [SW-1:0] mapBits(input logic [1:0] b);
        mapBits = {(b[1] ? NAMP : AMP), (b[0] ? NAMP : AMP)};
    endfunction

    function automatic logic [SW-1:0] rotate(input logic [SW-1:0] p, input logic [1:0] k);
        logic signed [DATA_W-1:0] re, im, nRe, nIm;
        re  = p[SW-1:DATA_W];
        im  = p[DATA_W-1:0];
        nRe = -re;
        nIm = -im;
        case (k)
            2'd1:    rotate = {nIm, re};
            2'd2:    rotate = {nRe, nIm};
            2'd3:    rotate = {im, nRe};
            default: rotate = {re, im};
        endcase
    endfunction

    assign wrWord            = {mapBits(frame_io.in_bits1), mapBits(frame_io.in_bits2)};
    assign wrEn              = frame_io.in_valid && !full_q[wrBank_q];
    assign frame_io.in_ready = !full_q[wrBank_q];

    // Write and read sides only ever touch opposite full bits in the same cycle.
    always_comb begin
        wrBank_d = wrBank_q;
        wrCnt_d  = wrCnt_q;
        full_d   = full_q;
        rdBank_d = rdBank_q;
        rdCnt_d  = rdCnt_q;
        state_d  = state_q;
        rot_d    = rot_q;
        rdEn     = 1'b0;
        if (wrEn) begin
            wrCnt_d = wrCnt_q + 1'b1;
            if (wrCnt_q == LAST) begin
                full_d[wrBank_q] = 1'b1;
                wrBank_d         = ~wrBank_q;
            end
        end
        case (state_q)
            IDLE: begin
                if (full_q[rdBank_q]) begin
                    state_d = RUN;
                    rot_d   = frame_io.quad_rot;
                    rdCnt_d = '0;
                    rdEn    = 1'b1;
                end
            end
            default: begin
                if (rdCnt_q == LAST) begin
                    full_d[rdBank_q] = 1'b0;
                    rdBank_d         = ~rdBank_q;
                    rdCnt_d          = '0;
                    if (full_q[~rdBank_q]) begin
                        rot_d = frame_io.quad_rot;
                        rdEn  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    rdCnt_d = rdCnt_q + 1'b1;
                    rdEn    = 1'b1;
                end
            end
        endcase
    end

    // The read is issued from the next-state address so tone 0 leaves the RAM on RUN entry.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[{wrBank_q, wrCnt_q}] <= wrWord;
        end
        if (rdEn) begin
            rdData_q <= mem[{rdBank_d, rdCnt_d}];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrBank_q   <= 1'b0;
            wrCnt_q    <= '0;
            full_q     <= 2'b00;
            rdBank_q   <= 1'b0;
            rdCnt_q    <= '0;
            state_q    <= IDLE;
            rot_q      <= 2'd0;
            rdValid_q  <= 1'b0;
            rdFirst_q  <= 1'b0;
            rdLast_q   <= 1'b0;
            outValid_q <= 1'b0;
            symStart_q <= 1'b0;
            symEnd_q   <= 1'b0;
            xOut_q     <= '0;
            symCnt_q   <= '0;
        end else begin
            wrBank_q   <= wrBank_d;
            wrCnt_q    <= wrCnt_d;
            full_q     <= full_d;
            rdBank_q   <= rdBank_d;
            rdCnt_q    <= rdCnt_d;
            state_q    <= state_d;
            rot_q      <= rot_d;
            rdValid_q  <= rdEn;
            rdFirst_q  <= rdEn && (rdCnt_d == '0);
            rdLast_q   <= rdEn && (rdCnt_d == LAST);
            outValid_q <= rdValid_q;
            symStart_q <= rdValid_q && rdFirst_q;
            symEnd_q   <= rdValid_q && rdLast_q;
            // rot_q still holds the previous symbol's rotation while its last tone drains here.
            xOut_q     <= rdValid_q ? {rotate(rdData_q[2*SW-1:SW], rot_q), rotate(rdData_q[SW-1:0], rot_q)}
                                    : '0;
            if (symEnd_q) begin
                symCnt_q <= symCnt_q + 16'd1;
            end
        end
    end

    assign frame_io.out_valid = outValid_q;
    assign frame_io.sym_start = symStart_q;
    assign frame_io.sym_end   = symEnd_q;
    assign frame_io.sym_cnt   = symCnt_q;
    assign frame_io.X1_re     = xOut_q[4*DATA_W-1:3*DATA_W];
    assign frame_io.X1_im     = xOut_q[3*DATA_W-1:2*DATA_W];
    assign frame_io.X2_re     = xOut_q[2*DATA_W-1:DATA_W];
    assign frame_io.X2_im     = xOut_q[DATA_W-1:0];
endmodule

// File: tb/tb_qpsk_symbol_framer.sv
// Directed bench for qpsk_symbol_framer: reset, mapping/latency, rotation, back-pressure,
// bubbly input and mid-symbol reset, checked against a tone scoreboard and hand constants.
module tb_qpsk_symbol_framer;
    localparam int                NFFT = 64;
    localparam logic signed [15:0] AMP = 16'sd1608;
    localparam logic [15:0]       PA   = 16'h0648;
    localparam logic [15:0]       NA   = 16'hF9B8;

    typedef struct packed {
        logic [63:0] x;
        logic        first;
        logic        last;
    } tone_t;

    logic  clk   = 1'b0;
    logic  rst_n = 1'b0;
    tone_t expQ[$];
    int    errors    = 0;
    int    checks    = 0;
    int    acceptCnt = 0;
    int    expSymCnt = 0;
    int    tonesSeen = 0;
    int    runLen    = 0;
    int    maxRun    = 0;
    logic  inSym     = 1'b0;
    logic  accepted  = 1'b0;

    always #5 clk = ~clk;

    qpsk_symbol_framer_if #(.DATA_W(16)) bus ();

    qpsk_symbol_framer #(.DATA_W(16), .NFFT(NFFT), .AMP(AMP)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .frame_io (bus)
    );

    function automatic logic [31:0] expPoint(input logic [1:0] b, input logic [1:0] k);
        logic signed [15:0] re, im, nRe, nIm;
        re  = b[1] ? -AMP : AMP;
        im  = b[0] ? -AMP : AMP;
        nRe = -re;
        nIm = -im;
        case (k)
            2'd1:    return {nIm, re};
            2'd2:    return {nRe, nIm};
            2'd3:    return {im, nRe};
            default: return {re, im};
        endcase
    endfunction

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic checkOutput();
        tone_t t;
        if (bus.out_valid) begin
            runLen++;
            if (runLen > maxRun) maxRun = runLen;
            if (expQ.size() == 0) begin
                checkVal("unexpected tone", 64'(bus.out_valid), 64'd0);
            end else begin
                t = expQ.pop_front();
                checkVal("tone samples", {bus.X1_re, bus.X1_im, bus.X2_re, bus.X2_im}, t.x);
                checkVal("start/end flags", {62'd0, bus.sym_start, bus.sym_end}, {62'd0, t.first, t.last});
                checkVal("sym_cnt during tone", 64'(bus.sym_cnt), 64'(expSymCnt));
                inSym = !t.last;
                if (t.last) expSymCnt = (expSymCnt + 1) % 65536;
                tonesSeen++;
            end
        end else begin
            runLen = 0;
            if (inSym) begin
                checkVal("gap inside symbol", 64'(bus.out_valid), 64'd1);
                inSym = 1'b0;
            end
        end
    endtask

    // Called at a falling edge: drive one cycle of input, record the transfer, check the next outputs.
    task automatic applyStimulus(input logic v, input logic [1:0] b1, input logic [1:0] b2, input logic [1:0] k);
        tone_t t;
        bus.in_valid = v;
        bus.in_bits1 = b1;
        bus.in_bits2 = b2;
        bus.quad_rot = k;
        #1;
        accepted = v && bus.in_ready;
        if (accepted) begin
            t.x     = {expPoint(b1, k), expPoint(b2, k)};
            t.first = (acceptCnt % NFFT) == 0;
            t.last  = (acceptCnt % NFFT) == NFFT - 1;
            expQ.push_back(t);
            acceptCnt++;
        end
        @(negedge clk);
        checkOutput();
    endtask

    task automatic drain(input int limit, input logic [1:0] k);
        int n = 0;
        while (expQ.size() != 0 && n < limit) begin
            applyStimulus(1'b0, 2'b00, 2'b00, k);
            n++;
        end
        checkVal("drain timeout", 64'(expQ.size()), 64'd0);
        repeat (3) applyStimulus(1'b0, 2'b00, 2'b00, k);
    endtask

    initial begin
        logic [31:0] rotExp [1:3];
        logic [7:0]  idx;
        int          n, base, baseT, stallAt;

        bus.in_valid = 1'b0;
        bus.in_bits1 = 2'b00;
        bus.in_bits2 = 2'b00;
        bus.quad_rot = 2'd0;

        repeat (5) @(negedge clk);
        checkVal("reset out_valid", 64'(bus.out_valid), 64'd0);
        checkVal("reset in_ready", 64'(bus.in_ready), 64'd1);
        checkVal("reset sym_cnt", 64'(bus.sym_cnt), 64'd0);
        checkVal("reset samples", {bus.X1_re, bus.X1_im, bus.X2_re, bus.X2_im}, 64'd0);
        checkVal("reset flags", {62'd0, bus.sym_start, bus.sym_end}, 64'd0);
        rst_n = 1'b1;

        $display("[TB] mapping and latency");
        for (int i = 0; i < NFFT; i++) applyStimulus(1'b1, 2'b00, 2'b11, 2'd0);
        checkVal("latency edge+0", 64'(bus.out_valid), 64'd0);
        applyStimulus(1'b0, 2'b00, 2'b00, 2'd0);
        checkVal("latency edge+1", 64'(bus.out_valid), 64'd0);
        applyStimulus(1'b0, 2'b00, 2'b00, 2'd0);
        checkVal("latency edge+2", 64'(bus.out_valid), 64'd1);
        checkVal("tone0 map", {bus.X1_re, bus.X1_im, bus.X2_re, bus.X2_im}, {PA, PA, NA, NA});
        checkVal("tone0 sym_start", 64'(bus.sym_start), 64'd1);
        drain(200, 2'd0);
        checkVal("sym_cnt after first symbol", 64'(bus.sym_cnt), 64'd1);

        $display("[TB] rotation");
        rotExp[1] = {NA, PA};
        rotExp[2] = {NA, NA};
        rotExp[3] = {PA, NA};
        for (int k = 1; k < 4; k++) begin
            for (int i = 0; i < NFFT; i++) applyStimulus(1'b1, 2'b00, 2'b00, 2'(k));
            applyStimulus(1'b0, 2'b00, 2'b00, 2'(k));
            applyStimulus(1'b0, 2'b00, 2'b00, 2'(k));
            checkVal("rotated X1 tone0", {bus.X1_re, bus.X1_im}, rotExp[k]);
            drain(200, 2'(k));
        end
        checkVal("sym_cnt after rotation", 64'(bus.sym_cnt), 64'd4);

        $display("[TB] back-pressure");
        base    = acceptCnt;
        stallAt = -1;
        maxRun  = 0;
        n       = 0;
        while (acceptCnt - base < 4 * NFFT && n < 1000) begin
            idx = 8'(acceptCnt - base);
            applyStimulus(1'b1, idx[3:2], idx[1:0], 2'd1);
            if (!accepted && stallAt < 0) stallAt = acceptCnt - base;
            n++;
        end
        checkVal("transfers before first stall", 64'(stallAt), 64'd128);
        drain(400, 2'd1);
        checkVal("gapless across symbols", 64'(maxRun >= 2 * NFFT), 64'd1);

        $display("[TB] bubbly input");
        base = acceptCnt;
        n    = 0;
        while (acceptCnt - base < 2 * NFFT && n < 2000) begin
            applyStimulus(1'($urandom_range(0, 99) < 30), 2'($urandom_range(0, 3)),
                          2'($urandom_range(0, 3)), 2'd2);
            n++;
        end
        checkVal("bubbly transfers", 64'(acceptCnt - base), 64'd128);
        drain(400, 2'd2);

        $display("[TB] mid-symbol reset");
        base  = acceptCnt;
        baseT = tonesSeen;
        n     = 0;
        while (tonesSeen - baseT < NFFT + 21 && n < 1000) begin
            if (acceptCnt - base < 2 * NFFT) begin
                idx = 8'(acceptCnt - base);
                applyStimulus(1'b1, idx[3:2], idx[1:0], 2'd3);
            end else begin
                applyStimulus(1'b0, 2'b00, 2'b00, 2'd3);
            end
            n++;
        end
        checkVal("reached tone 20 of symbol 2", 64'(tonesSeen - baseT), 64'(NFFT + 21));
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        #1;
        checkVal("abort out_valid", 64'(bus.out_valid), 64'd0);
        checkVal("abort samples", {bus.X1_re, bus.X1_im, bus.X2_re, bus.X2_im}, 64'd0);
        checkVal("abort in_ready", 64'(bus.in_ready), 64'd1);
        checkVal("abort sym_cnt", 64'(bus.sym_cnt), 64'd0);
        expQ.delete();
        acceptCnt = 0;
        expSymCnt = 0;
        inSym     = 1'b0;
        runLen    = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NFFT; i++) begin
            idx = 8'(i);
            applyStimulus(1'b1, idx[5:4], idx[1:0], 2'd0);
        end
        drain(200, 2'd0);
        checkVal("sym_cnt after reset symbol", 64'(bus.sym_cnt), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
